// File: rtl/nes_clk_pkg.sv
// nes_clk_pkg: shared NES clock constants, m2 tracker state type and tolerance helper
package nes_clk_pkg;
  localparam int M2_HIGH_NOM = 8;
  localparam int M2_LOW_NOM = 16;
  localparam int M2_PERIOD = M2_HIGH_NOM + M2_LOW_NOM;
  typedef enum logic [1:0] {M2_SEARCH, M2_MEASURE, M2_LOCKED} m2_state_t;
  function automatic logic within_tol(input logic [4:0] v, input int nom, input int tol);
    return (int'(v) >= nom - tol) && (int'(v) <= nom + tol);
  endfunction
endpackage

// File: rtl/nes_sync_edge.sv
// nes_sync_edge: multi-flop synchronizer with registered level and rise/fall pulses
module nes_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    lvl_d = sync_q[STAGES-1];
    rise_d = lvl_d & ~lvl_q;
    fall_d = ~lvl_d & lvl_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      lvl_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign lvl = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/nes_m2_tracker.sv
// nes_m2_tracker: recovers CPU cycle phase from m2, verifies its timing and emits locked write strobes
module nes_m2_tracker
  import nes_clk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int M2_HIGH = M2_HIGH_NOM,
  parameter int M2_LOW = M2_LOW_NOM,
  parameter int TOL = 1,
  parameter int LOCK_PERIODS = 3
) (
  input  logic        clk_master,
  input  logic        rst_master,
  input  logic        m2,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_rw,
  output logic        m2_rise,
  output logic        m2_fall,
  output logic [4:0]  phase,
  output logic        locked,
  output logic        lock_err,
  output logic [7:0]  err_cnt,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data
);
  localparam int PERIOD = M2_HIGH + M2_LOW;
  localparam int TIMEOUT = 2 * PERIOD;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_PERIODS + 1);
  m2_state_t state_q, state_d;
  logic [4:0] hi_q, hi_d, lo_q, lo_d, phase_q, phase_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [GW-1:0] good_q, good_d;
  logic [7:0] err_q, err_d, wr_data_q, wr_data_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic lock_err_q, lock_err_d, wr_en_q, wr_en_d;
  logic lvl, rise, fall, good, timeout, lose;
  nes_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk_master),
    .rst(rst_master),
    .d(m2),
    .lvl(lvl),
    .rise(rise),
    .fall(fall)
  );
  // an edge in the same cycle always beats the idle timeout
  always_comb begin
    good = within_tol(lo_q, M2_LOW, TOL) && within_tol(hi_q, M2_HIGH, TOL);
    timeout = !rise && !fall && idle_q == IW'(TIMEOUT - 1);
    state_d = state_q;
    good_d = good_q;
    lose = 1'b0;
    case (state_q)
      M2_SEARCH: begin
        state_d = rise ? M2_MEASURE : M2_SEARCH;
        good_d = rise ? '0 : good_q;
      end
      M2_MEASURE: begin
        if (rise) begin
          good_d = good ? good_q + GW'(1) : '0;
          state_d = (good && good_q == GW'(LOCK_PERIODS - 1)) ? M2_LOCKED : M2_MEASURE;
        end else if (timeout) begin
          state_d = M2_SEARCH;
        end
      end
      M2_LOCKED: begin
        lose = rise ? !good : timeout;
        state_d = lose ? M2_SEARCH : M2_LOCKED;
      end
      default: state_d = M2_SEARCH;
    endcase
  end
  always_comb begin
    locked = state_q == M2_LOCKED;
  end
  always_comb begin
    hi_d = rise ? 5'd1 : (lvl && hi_q != 5'd31) ? hi_q + 5'd1 : hi_q;
    lo_d = fall ? 5'd1 : (!lvl && lo_q != 5'd31) ? lo_q + 5'd1 : lo_q;
    phase_d = (rise || phase_q == 5'(PERIOD - 1)) ? 5'd0 : phase_q + 5'd1;
    idle_d = (rise || fall || state_q == M2_SEARCH) ? '0 : idle_q + IW'(1);
    err_d = (lose && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    lock_err_d = lose;
    wr_en_d = fall && state_q == M2_LOCKED && !cpu_rw;
    wr_addr_d = wr_en_d ? cpu_addr : wr_addr_q;
    wr_data_d = wr_en_d ? cpu_data : wr_data_q;
  end
  always_ff @(posedge clk_master) begin
    if (rst_master) begin
      state_q <= M2_SEARCH;
      good_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      phase_q <= '0;
      idle_q <= '0;
      err_q <= '0;
      lock_err_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      good_q <= good_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      phase_q <= phase_d;
      idle_q <= idle_d;
      err_q <= err_d;
      lock_err_q <= lock_err_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign m2_rise = rise;
  assign m2_fall = fall;
  assign phase = phase_q;
  assign lock_err = lock_err_q;
  assign err_cnt = err_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
endmodule

// File: tb/tb_nes_m2_tracker.sv
// tb_nes_m2_tracker: drives m2 as high/low segments and checks against a per-segment timing model
module tb_nes_m2_tracker;
  logic clk_master = 1'b0, rst_master = 1'b1, m2 = 1'b0, cpu_rw = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_data = '0;
  logic m2_rise, m2_fall, locked, lock_err, wr_en;
  logic [4:0] phase;
  logic [7:0] err_cnt, wr_data;
  logic [15:0] wr_addr;
  int passed = 0, total = 0;
  int cyc = 0, rise_cyc = -100, fall_cyc = -100, wr_seen = 0, lerr_seen = 0;
  bit m_locked = 0, m_meas = 0;
  int m_good = 0, m_errs = 0, m_wr = 0, m_lerr = 0, last_hi = 0, last_lo = 0;
  logic [15:0] m_addr = '0;
  logic [7:0] m_data = '0;

  nes_m2_tracker dut (
    .clk_master(clk_master), .rst_master(rst_master), .m2(m2),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_rw(cpu_rw),
    .m2_rise(m2_rise), .m2_fall(m2_fall), .phase(phase), .locked(locked),
    .lock_err(lock_err), .err_cnt(err_cnt), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk_master = ~clk_master;
  always @(posedge clk_master) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk_master) begin
    if (wr_en) begin
      wr_seen++;
      chk("wr_latency", cyc - fall_cyc, 4);
    end
    if (lock_err) lerr_seen++;
    if (m2_rise) chk("rise_latency", cyc - rise_cyc, 3);
    if (m2_fall) chk("fall_latency", cyc - fall_cyc, 3);
  end

  function automatic bit period_ok(input int h, input int l);
    return h >= 7 && h <= 9 && l >= 15 && l <= 17;
  endfunction

  task automatic model_lose();
    m_locked = 0;
    m_meas = 0;
    m_errs = (m_errs < 255) ? m_errs + 1 : 255;
    m_lerr++;
  endtask

  task automatic model(input logic lv, input int len, input logic rw, input logic [15:0] a,
                       input logic [7:0] d, input bit rst_mid);
    if (rst_mid) begin
      m_locked = 0; m_meas = 0; m_good = 0; m_errs = 0; m_addr = '0; m_data = '0;
      return;
    end
    if (lv) begin
      if (m_locked) begin
        if (!period_ok(last_hi, last_lo)) model_lose();
      end else if (m_meas) begin
        m_good = period_ok(last_hi, last_lo) ? m_good + 1 : 0;
        if (m_good == 3) begin m_locked = 1; m_meas = 0; end
      end else begin
        m_meas = 1;
        m_good = 0;
      end
      last_hi = len;
    end else begin
      if (m_locked && !rw) begin m_wr++; m_addr = a; m_data = d; end
      last_lo = len;
    end
    if (len >= 48 && (m_locked || m_meas)) begin
      if (m_locked) model_lose();
      m_meas = 0;
    end
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_rise"}, m2_rise, 0);
    chk({tag, "_fall"}, m2_fall, 0);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_lock_err"}, lock_err, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
  endtask

  task automatic seg(input logic lv, input int len, input logic rw, input logic [15:0] a,
                     input logic [7:0] d, input int rst_at);
    model(lv, len, rw, a, d, rst_at >= 0);
    for (int i = 0; i < len; i++) begin
      @(posedge clk_master); #1;
      if (i == 0) begin
        m2 = lv;
        if (lv) rise_cyc = cyc;
        else begin
          fall_cyc = cyc;
          cpu_rw = rw; cpu_addr = a; cpu_data = d;
        end
      end
      rst_master = (i == rst_at);
      if (rst_at >= 0 && i == rst_at + 1) zero_checks("midrst");
    end
    chk("locked", locked, m_locked);
    chk("err_cnt", err_cnt, m_errs);
    chk("wr_count", wr_seen, m_wr);
    chk("lock_err_count", lerr_seen, m_lerr);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, m_data);
  endtask

  task automatic period(input int h, input int l, input logic rw, input logic [15:0] a, input logic [7:0] d);
    seg(1'b1, h, 1'b1, '0, '0, -1);
    seg(1'b0, l, rw, a, d, -1);
  endtask

  initial begin
    repeat (3) @(posedge clk_master);
    #1;
    zero_checks("reset");
    rst_master = 1'b0;
    // nominal lock: the 4th rise (3rd good period) locks
    repeat (3) period(8, 16, 1'b1, 16'h0, 8'h0);
    chk("t1_not_locked", locked, 0);
    seg(1'b1, 8, 1'b1, '0, '0, -1);
    chk("t1_locked", locked, 1);
    chk("t1_err_cnt", err_cnt, 0);
    seg(1'b0, 16, 1'b0, 16'h8000, 8'hA5, -1);
    chk("t2_wr_count", wr_seen, 1);
    chk("t2_wr_addr", wr_addr, 16'h8000);
    chk("t2_wr_data", wr_data, 8'hA5);
    period(8, 16, 1'b1, 16'h1234, 8'h5A);
    chk("t2_read_no_wr", wr_seen, 1);
    period(10, 16, 1'b1, '0, '0);
    seg(1'b1, 8, 1'b1, '0, '0, -1);
    chk("t3_lock_err", lerr_seen, 1);
    chk("t3_unlocked", locked, 0);
    chk("t3_err_cnt", err_cnt, 1);
    seg(1'b0, 16, 1'b1, '0, '0, -1);
    repeat (3) period(8, 16, 1'b1, '0, '0);
    seg(1'b1, 8, 1'b1, '0, '0, -1);
    chk("t3_relocked", locked, 1);
    seg(1'b0, 16, 1'b1, '0, '0, -1);
    seg(1'b1, 8, 1'b1, '0, '0, -1);
    seg(1'b0, 60, 1'b1, 16'h4015, 8'h0F, -1);
    chk("t4_unlocked", locked, 0);
    chk("t4_lock_err", lerr_seen, 2);
    chk("t4_no_wr", wr_seen, 1);
    for (int k = 0; k < 80; k++)
      period($urandom_range(10, 6), $urandom_range(18, 14), 1'(($urandom_range(1, 0))),
             16'($urandom), 8'($urandom));
    for (int k = 0; k < 3000 && m_lerr < 262; k++)
      period(m_locked ? 12 : 8, 16, 1'b1, '0, '0);
    chk("t5_err_sat", err_cnt, 8'hFF);
    for (int k = 0; k < 10 && !m_locked; k++) period(8, 16, 1'b1, '0, '0);
    seg(1'b1, 8, 1'b1, '0, '0, -1);
    chk("t6_pre_locked", locked, 1);
    seg(1'b0, 16, 1'b0, 16'hC000, 8'h3C, 3);
    chk("t6_wr_dropped", wr_seen, m_wr);
    repeat (4) period(8, 16, 1'b1, '0, '0);
    seg(1'b1, 8, 1'b1, '0, '0, -1);
    chk("t6_relocked", locked, 1);
    chk("t6_err_cnt", err_cnt, 0);
    seg(1'b0, 16, 1'b0, 16'hA001, 8'h80, -1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
